// File: rtl/exp_align_sequencer.sv
// exp_align_sequencer: orders two FP operands by exponent and right-aligns the
// smaller mantissa with an iterative STEP-bit shifter, collecting G/R/S bits.
module exp_align_sequencer #(
   parameter int SIZE_EXP = 8,
   parameter int SIZE_MAN = 23,
   parameter int STEP     = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [SIZE_EXP-1:0]   i_exp_a,
   input  logic [SIZE_EXP-1:0]   i_exp_b,
   input  logic [SIZE_MAN:0]     i_man_a,
   input  logic [SIZE_MAN:0]     i_man_b,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_swap,
   output logic [SIZE_EXP-1:0]   o_exp_greater,
   output logic [SIZE_EXP-1:0]   o_diff_value,
   output logic [SIZE_MAN:0]     o_man_greater,
   output logic [SIZE_MAN+3:0]   o_man_aligned
);

   localparam int W  = SIZE_MAN + 1;
   localparam int AW = W + 3;               // mantissa plus G, R, S
   localparam int RW = $clog2(AW + 1);      // remaining-shift counter width

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]          state_q, state_d;
   logic                swap_q, swap_d;
   logic [SIZE_EXP-1:0] exp_greater_q, exp_greater_d;
   logic [SIZE_EXP-1:0] diff_q, diff_d;
   logic [W-1:0]        man_greater_q, man_greater_d;
   logic [AW-1:0]       aligned_q, aligned_d;
   logic [RW-1:0]       rem_q, rem_d;
   logic                valid_q, valid_d;
   logic                ready_q, ready_d;

   logic                a_lt_b_s;
   logic [SIZE_EXP-1:0] diff_in_s;
   logic [RW-1:0]       rem_in_s;
   logic [RW-1:0]       k_s;
   logic [AW-1:0]       mask_s;
   logic [AW-1:0]       shifted_s;
   logic                sticky_s;
   logic [AW-1:0]       shift_next_s;

   // Operand ordering, exponent difference and clipped shift amount at accept
   always_comb begin
      a_lt_b_s  = (i_exp_a < i_exp_b);
      diff_in_s = a_lt_b_s ? (i_exp_b - i_exp_a) : (i_exp_a - i_exp_b);
      if (32'(diff_in_s) >= 32'(AW)) begin
         rem_in_s = RW'(AW);
      end else begin
         rem_in_s = RW'(diff_in_s);
      end
   end

   // One shifter step: move right by min(rem, STEP) and fold dropped bits into S
   always_comb begin
      if (rem_q < RW'(STEP)) begin
         k_s = rem_q;
      end else begin
         k_s = RW'(STEP);
      end
      mask_s       = ~({AW{1'b1}} << k_s);
      shifted_s    = aligned_q >> k_s;
      sticky_s     = |(aligned_q & mask_s);
      shift_next_s = {shifted_s[AW-1:1], shifted_s[0] | sticky_s};
   end

   // Next-state and datapath register update
   always_comb begin
      state_d       = state_q;
      swap_d        = swap_q;
      exp_greater_d = exp_greater_q;
      diff_d        = diff_q;
      man_greater_d = man_greater_q;
      aligned_d     = aligned_q;
      rem_d         = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               swap_d        = a_lt_b_s;
               exp_greater_d = a_lt_b_s ? i_exp_b : i_exp_a;
               diff_d        = diff_in_s;
               man_greater_d = a_lt_b_s ? i_man_b : i_man_a;
               aligned_d     = {(a_lt_b_s ? i_man_a : i_man_b), 3'b000};
               rem_d         = rem_in_s;
               state_d       = (rem_in_s == {RW{1'b0}}) ? ST_DONE : ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            aligned_d = shift_next_s;
            rem_d     = rem_q - k_s;
            if (rem_q == k_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      valid_d = (state_d == ST_DONE);
      ready_d = (state_d == ST_IDLE);
   end

   // State and output registers; reset discards any operation in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         swap_q        <= 1'b0;
         exp_greater_q <= {SIZE_EXP{1'b0}};
         diff_q        <= {SIZE_EXP{1'b0}};
         man_greater_q <= {W{1'b0}};
         aligned_q     <= {AW{1'b0}};
         rem_q         <= {RW{1'b0}};
         valid_q       <= 1'b0;
         ready_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         swap_q        <= swap_d;
         exp_greater_q <= exp_greater_d;
         diff_q        <= diff_d;
         man_greater_q <= man_greater_d;
         aligned_q     <= aligned_d;
         rem_q         <= rem_d;
         valid_q       <= valid_d;
         ready_q       <= ready_d;
      end
   end

   assign o_ready       = ready_q;
   assign o_valid       = valid_q;
   assign o_swap        = swap_q;
   assign o_exp_greater = exp_greater_q;
   assign o_diff_value  = diff_q;
   assign o_man_greater = man_greater_q;
   assign o_man_aligned = aligned_q;

endmodule

// File: tb/tb_exp_align_sequencer.sv
// Directed + scoreboard bench for exp_align_sequencer (default parameters).
module tb_exp_align_sequencer;

   typedef struct {
      logic        swap;
      logic [7:0]  eg;
      logic [7:0]  dv;
      logic [23:0] mg;
      logic [26:0] al;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [7:0]  i_exp_a;
   logic [7:0]  i_exp_b;
   logic [23:0] i_man_a;
   logic [23:0] i_man_b;
   logic        o_valid;
   logic        i_ready;
   logic        o_swap;
   logic [7:0]  o_exp_greater;
   logic [7:0]  o_diff_value;
   logic [23:0] o_man_greater;
   logic [26:0] o_man_aligned;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   exp_align_sequencer #(.SIZE_EXP(8), .SIZE_MAN(23), .STEP(4)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_exp_a(i_exp_a), .i_exp_b(i_exp_b), .i_man_a(i_man_a), .i_man_b(i_man_b),
      .o_valid(o_valid), .i_ready(i_ready), .o_swap(o_swap),
      .o_exp_greater(o_exp_greater), .o_diff_value(o_diff_value),
      .o_man_greater(o_man_greater), .o_man_aligned(o_man_aligned)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [26:0] align_model(input logic [23:0] m, input int d);
      logic [26:0] full;
      logic [26:0] mask;
      full = {m, 3'b000};
      if (d >= 27) begin
         return {26'd0, |m};
      end
      mask = (27'd1 << d) - 27'd1;
      return (full >> d) | {26'd0, |(full & mask)};
   endfunction

   function automatic exp_t model(input logic [7:0] ea, input logic [7:0] eb,
                                  input logic [23:0] ma, input logic [23:0] mb);
      exp_t e;
      int   d;
      int   c;
      e.swap = (ea < eb);
      e.eg   = e.swap ? eb : ea;
      d      = e.swap ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
      e.dv   = 8'(d);
      e.mg   = e.swap ? mb : ma;
      e.al   = align_model(e.swap ? ma : mb, d);
      c      = (d > 27) ? 27 : d;
      e.lat  = (c + 3) / 4;
      return e;
   endfunction

   function automatic exp_t mk(input logic sw, input logic [7:0] eg, input logic [7:0] dv,
                               input logic [23:0] mg, input logic [26:0] al, input int lat);
      exp_t e;
      e.swap = sw; e.eg = eg; e.dv = dv; e.mg = mg; e.al = al; e.lat = lat;
      return e;
   endfunction

   // Drive one operand pair, wait for the result, score it, optionally release it
   task automatic do_op(input logic [7:0] ea, input logic [7:0] eb,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input exp_t e, input bit rel);
      int   guard;
      int   lat;
      exp_t cur;
      guard = 0;
      while (o_ready !== 1'b1 && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      chk("ready_before_accept", 64'(o_ready), 64'(1));
      i_exp_a = ea; i_exp_b = eb; i_man_a = ma; i_man_b = mb;
      i_valid = 1'b1;
      sb_q.push_back(e);
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("ready_busy", 64'(o_ready), 64'(0));
      lat = 0;
      while (o_valid !== 1'b1 && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      cur = sb_q.pop_front();
      chk("latency", 64'(lat), 64'(cur.lat));
      chk("swap", 64'(o_swap), 64'(cur.swap));
      chk("exp_greater", 64'(o_exp_greater), 64'(cur.eg));
      chk("diff_value", 64'(o_diff_value), 64'(cur.dv));
      chk("man_greater", 64'(o_man_greater), 64'(cur.mg));
      chk("man_aligned", 64'(o_man_aligned), 64'(cur.al));
      chk("ready_in_done", 64'(o_ready), 64'(0));
      if (rel) begin
         i_ready = 1'b1;
         @(posedge clk); #1;
         i_ready = 1'b0;
         chk("valid_after_release", 64'(o_valid), 64'(0));
         chk("ready_after_release", 64'(o_ready), 64'(1));
      end
   endtask

   initial begin
      logic [7:0]  ea;
      logic [7:0]  eb;
      logic [23:0] ma;
      logic [23:0] mb;

      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
      i_exp_a = 8'd0; i_exp_b = 8'd0; i_man_a = 24'd0; i_man_b = 24'd0;
      #12;
      chk("rst_ready", 64'(o_ready), 64'(1));
      chk("rst_valid", 64'(o_valid), 64'(0));
      chk("rst_aligned", 64'(o_man_aligned), 64'(0));
      chk("rst_diff", 64'(o_diff_value), 64'(0));
      #5 i_rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: basic shift, no sticky
      do_op(8'd130, 8'd128, 24'h800000, 24'hC00001,
            mk(1'b0, 8'd130, 8'd2, 24'h800000, 27'h1800002, 1), 1'b1);
      // 2: sticky accumulated across two steps
      do_op(8'd133, 8'd128, 24'h800000, 24'h800011,
            mk(1'b0, 8'd133, 8'd5, 24'h800000, 27'h0200005, 2), 1'b1);
      // 3: swap and clip
      do_op(8'd100, 8'd150, 24'h800000, 24'hC00001,
            mk(1'b1, 8'd150, 8'd50, 24'hC00001, 27'h0000001, 7), 1'b1);
      // 4: equal exponents never swap
      do_op(8'd127, 8'd127, 24'h800000, 24'hFFFFFF,
            mk(1'b0, 8'd127, 8'd0, 24'h800000, 27'h7FFFFF8, 0), 1'b1);

      // 5: backpressure in DONE while new operands are offered
      do_op(8'd133, 8'd128, 24'h800000, 24'h800011,
            mk(1'b0, 8'd133, 8'd5, 24'h800000, 27'h0200005, 2), 1'b0);
      for (int i = 0; i < 5; i++) begin
         i_valid = 1'b1; i_exp_a = 8'd10; i_exp_b = 8'd90;
         i_man_a = 24'hABCDEF; i_man_b = 24'h900000; i_ready = 1'b0;
         @(posedge clk); #1;
         chk("bp_valid", 64'(o_valid), 64'(1));
         chk("bp_ready", 64'(o_ready), 64'(0));
         chk("bp_aligned", 64'(o_man_aligned), 64'(27'h0200005));
         chk("bp_diff", 64'(o_diff_value), 64'(5));
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      chk("bp_release_ready", 64'(o_ready), 64'(1));
      chk("bp_release_valid", 64'(o_valid), 64'(0));
      chk("bp_not_captured", 64'(o_exp_greater), 64'(133));
      @(posedge clk); #1;
      chk("bp_idle_valid", 64'(o_valid), 64'(0));

      // 6: reset in the third SHIFT cycle of scenario 3
      i_exp_a = 8'd100; i_exp_b = 8'd150; i_man_a = 24'h800000; i_man_b = 24'hC00001;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_shift_busy", 64'(o_ready), 64'(0));
      i_rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(o_valid), 64'(0));
      chk("midrst_ready", 64'(o_ready), 64'(1));
      chk("midrst_aligned", 64'(o_man_aligned), 64'(0));
      chk("midrst_swap", 64'(o_swap), 64'(0));
      chk("midrst_expg", 64'(o_exp_greater), 64'(0));
      #10 i_rst_n = 1'b1;
      @(posedge clk); #1;
      chk("postrst_valid", 64'(o_valid), 64'(0));
      do_op(8'd130, 8'd128, 24'h800000, 24'hC00001,
            mk(1'b0, 8'd130, 8'd2, 24'h800000, 27'h1800002, 1), 1'b1);

      // Clip boundary: diff exactly 26 and 27
      do_op(8'd200, 8'd174, 24'h800000, 24'hC00003,
            model(8'd200, 8'd174, 24'h800000, 24'hC00003), 1'b1);
      do_op(8'd173, 8'd200, 24'h812345, 24'hFFFFFF,
            model(8'd173, 8'd200, 24'h812345, 24'hFFFFFF), 1'b1);

      // Random operand pairs scored against the reference model
      for (int i = 0; i < 6; i++) begin
         ea = 8'($urandom_range(0, 255));
         eb = 8'($urandom_range(0, 255));
         if (i < 3) begin
            eb = 8'(ea + 8'($urandom_range(0, 30)));
         end
         ma = {1'b1, 23'($urandom)};
         mb = {1'b1, 23'($urandom)};
         do_op(ea, eb, ma, mb, model(ea, eb, ma, mb), 1'b1);
      end

      chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exp_align_sequencer.md
Name: exp_align_sequencer

Overview:
Multi-cycle operand-alignment controller for the FP add/sub path. Accepts two exponent/mantissa pairs over a valid/ready handshake and orders them (greater exponent first, equal exponents keep A). It then right-shifts the smaller-exponent mantissa by the exponent difference, STEP bits per cycle, accumulating G/R/S bits. Sits between operand unpack and the mantissa adder; replaces a full-width barrel shifter with a small iterative one.

Parameters:
SIZE_EXP, 8, exponent width
SIZE_MAN, 23, stored fraction width; W = SIZE_MAN+1 (hidden bit included in inputs)
STEP, 4, max right-shift bits per SHIFT cycle (1..W+3)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  operand pair valid
o_ready  out  1  block can accept operands
i_exp_a  in  SIZE_EXP  exponent A
i_exp_b  in  SIZE_EXP  exponent B
i_man_a  in  W  mantissa A incl. hidden bit
i_man_b  in  W  mantissa B incl. hidden bit
o_valid  out  1  aligned result valid
i_ready  in  1  downstream accepts result
o_swap  out  1  0: exp_a >= exp_b; 1: exp_a < exp_b
o_exp_greater  out  SIZE_EXP  larger exponent
o_diff_value  out  SIZE_EXP  greater minus less (unclipped)
o_man_greater  out  W  mantissa of greater-exponent operand
o_man_aligned  out  W+3  shifted smaller mantissa {bits, G, R, S}

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all registered outputs 0; o_valid=0; o_ready=1 (o_ready = state==IDLE). Reset mid-SHIFT/DONE discards the operation; no partial result is emitted.
- FSM: IDLE, SHIFT, DONE.
- IDLE: on edge with i_valid=1, capture:
  - swap = (exp_a < exp_b); diff = greater-less, unsigned, no wrap.
  - o_man_greater = greater mantissa.
  - Aligned register = {smaller mantissa, 3'b000}.
  - rem = min(diff, W+3).
  - rem==0 -> DONE; else -> SHIFT. i_valid=0 -> stay IDLE.
- SHIFT: each edge uses k = min(rem, STEP).
  - reg <= reg >> k, with new bit0 = (shifted bit0) OR (OR of the k bits shifted out, including old bit0). Sticky is never lost.
  - rem <= rem - k. Go to DONE when rem-k == 0.
  - Shift cycles = ceil(rem/STEP).
- DONE: o_valid=1; all outputs held stable until an edge with i_ready=1, then -> IDLE, o_valid=0.
  - o_ready=0 in SHIFT and DONE; i_valid there is ignored, not queued.
  - One-cycle bubble between results; no same-cycle accept from DONE.
- Latency: accept at edge k -> o_valid high after edge k + ceil(min(diff,W+3)/STEP). diff=0 gives o_valid in the cycle after accept.
- Clip: diff >= W+3 yields aligned = all zero except S = OR(smaller mantissa). o_diff_value still reports the true diff.
- o_swap, o_exp_greater, o_diff_value and o_man_greater are registered at accept and constant through SHIFT/DONE.
- Mantissa magnitudes are not compared; equal exponents never swap.

Test Plan:
(Defaults W=24, output 27 bits, STEP=4.)
1. Basic shift, no sticky: exp_a=130, exp_b=128, man_a=0x800000, man_b=0xC00001 -> o_swap=0, o_exp_greater=130, o_diff_value=2, o_man_greater=0x800000, o_man_aligned=0x1800002; o_valid 1 edge after accept.
2. Sticky across steps: exp_a=133, exp_b=128, man_b=0xC00001 replaced by 0x800011 -> after step 1 reg=0x400009, after step 2 o_man_aligned=0x200005; o_valid 2 edges after accept.
3. Swap and clip: exp_a=100, exp_b=150, man_a=0x800000 -> o_swap=1, o_exp_greater=150, o_diff_value=50, o_man_aligned=0x0000001; o_valid 7 edges after accept.
4. Equal exponents: exp_a=exp_b=127, man_b=0xFFFFFF -> o_swap=0, o_diff_value=0, o_man_aligned=0x7FFFFF8; o_valid in the cycle after accept.
5. Backpressure: hold i_ready=0 for 5 cycles in DONE while pulsing i_valid with new operands -> o_valid stays 1, outputs unchanged, o_ready=0, new operands not captured. Release i_ready -> IDLE, o_ready=1 next cycle.
6. Reset mid-operation: assert i_rst_n=0 in the 3rd SHIFT cycle of scenario 3 -> immediately o_valid=0, outputs 0, o_ready=1. After release, scenario 1 completes with identical results.
